// File: rtl/targetc_axil_regfile.sv
// AXI4-Lite slave register file for the TARGETC prototype: R/W control bank,
// a live status word and a write-1-to-pulse command word.
module targetc_axil_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [32*NUM_REGS-1:0]          ctrl_regs,
  input  logic [31:0]                     status_in,
  output logic [31:0]                     cmd_pulse
);

  localparam logic [3:0] IDX_STATUS = 4'h4;
  localparam logic [3:0] IDX_CMD    = 4'h5;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic        rdy_en;
  logic        aw_full, w_full;
  logic [3:0]  aw_idx;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic [31:0] regs [NUM_REGS];
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic [3:0]  ar_idx;
  logic        aw_hs, w_hs, ar_hs, commit;
  logic        unused_inputs;

  function automatic logic is_ctrl(input logic [3:0] idx);
    return idx < 4'(NUM_REGS);
  endfunction

  function automatic logic [1:0] resp_for(input logic [3:0] idx);
    if (is_ctrl(idx) || idx == IDX_STATUS || idx == IDX_CMD) return RESP_OKAY;
    return RESP_SLVERR;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  assign unused_inputs = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // rdy_en keeps every READY low during reset and for the cycle that follows
  assign S_AXI_AWREADY = rdy_en & ~aw_full & ~S_AXI_BVALID;
  assign S_AXI_WREADY  = rdy_en & ~w_full  & ~S_AXI_BVALID;
  assign S_AXI_ARREADY = rdy_en & ~S_AXI_RVALID;

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID  & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = aw_full & w_full & ~S_AXI_BVALID;
  assign ar_idx = S_AXI_ARADDR[5:2];

  always_comb begin
    rd_data = '0;
    rd_resp = resp_for(ar_idx);
    for (int k = 0; k < NUM_REGS; k++)
      if (ar_idx == 4'(k)) rd_data = regs[k];
    if (!is_ctrl(ar_idx) && ar_idx == IDX_STATUS) rd_data = status_in;
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_ctrl
    assign ctrl_regs[32*k +: 32] = regs[k];
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rdy_en       <= 1'b0;
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RRESP  <= RESP_OKAY;
      S_AXI_RDATA  <= '0;
      cmd_pulse    <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      rdy_en    <= 1'b1;
      cmd_pulse <= '0;

      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[5:2];
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end

      // Control registers shadow STATUS/CMD when the bank is large enough
      if (commit) begin
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= resp_for(aw_idx);
        for (int k = 0; k < NUM_REGS; k++)
          if (aw_idx == 4'(k))
            for (int b = 0; b < 4; b++)
              if (w_strb[b]) regs[k][8*b +: 8] <= w_data[8*b +: 8];
        if (!is_ctrl(aw_idx) && aw_idx == IDX_CMD)
          cmd_pulse <= w_data & strb_mask(w_strb);
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
        S_AXI_BRESP  <= RESP_OKAY;
      end

      if (ar_hs) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_data;
        S_AXI_RRESP  <= rd_resp;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
        S_AXI_RDATA  <= '0;
        S_AXI_RRESP  <= RESP_OKAY;
      end
    end
  end

endmodule

// File: doc/targetc_axil_regfile.md
# targetc_axil_regfile

AXI4-Lite slave register file for the TARGETC prototype IP, sitting directly downstream of the PS/VIP AXI4-Lite master on the S00_AXI port. It decodes single-beat reads and writes into a bank of read/write control registers, one read-only status word and one write-1-to-pulse command word. The control outputs drive the TARGETC control logic.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6: byte address width; bits [1:0] are ignored.
- NUM_REGS, 4: number of R/W control registers, 1..8, mapped at 0x00, 0x04, …

Ports:
- S_AXI_ACLK  in  1  the only clock.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR / S_AXI_AWPROT / S_AXI_AWVALID  in  6/3/1  write address channel; AWPROT is ignored.
- S_AXI_AWREADY  out  1  write address accept.
- S_AXI_WDATA / S_AXI_WSTRB / S_AXI_WVALID  in  32/4/1  write data channel.
- S_AXI_WREADY  out  1  write data accept.
- S_AXI_BRESP / S_AXI_BVALID  out  2/1  write response.
- S_AXI_BREADY  in  1  write response accept.
- S_AXI_ARADDR / S_AXI_ARPROT / S_AXI_ARVALID  in  6/3/1  read address channel; ARPROT is ignored.
- S_AXI_ARREADY  out  1  read address accept.
- S_AXI_RDATA / S_AXI_RRESP / S_AXI_RVALID  out  32/2/1  read data channel.
- S_AXI_RREADY  in  1  read data accept.
- ctrl_regs  out  32*NUM_REGS  contents of the control registers; register k occupies [32k+31:32k].
- status_in  in  32  live status word, synchronous to S_AXI_ACLK.
- cmd_pulse  out  32  one-cycle pulse for each bit written as 1 to CMD.

## Operation
Address map (word index = addr[5:2]):
- 0 .. NUM_REGS-1: control registers, read/write, byte-strobed.
- 0x10 STATUS: read returns status_in, sampled in the AR handshake cycle. A write has no effect and returns OKAY.
- 0x14 CMD: a write sets cmd_pulse = WDATA masked by WSTRB for exactly one cycle. A read returns 0.
- Any other index: a write has no effect and returns SLVERR (2'b10). A read returns 0 with SLVERR.
- If NUM_REGS ≥ 5 and the control registers overlap 0x10/0x14, the control registers take priority.

Write path:
- The AW and W buffers are independent, one entry each.
- AWREADY = aw_empty & ~BVALID.
- WREADY = w_empty & ~BVALID.
- A buffer captures its channel on the handshake edge.
- When both buffers are full and BVALID=0, the write commits on the next edge. On that edge BVALID rises, BRESP is set and both buffers empty.
- Byte lane b of the target register is updated only where WSTRB[b]=1.
- BVALID is held until BREADY. It clears on the edge where BVALID & BREADY.
- AW-before-W, W-before-AW and simultaneous arrival are all legal and produce identical results.

Read path:
- ARREADY = ~RVALID.
- On the AR handshake edge, RDATA and RRESP are latched and RVALID rises.
- RDATA, RRESP and RVALID are held stable until RREADY. They clear on the edge where RVALID & RREADY.
- A read and a write commit to the same register in the same cycle: the read returns the pre-write value.

## Timing
- Reset values: all ctrl_regs 0, cmd_pulse 0, BVALID 0, RVALID 0, BRESP 0, RRESP 0, RDATA 0, AWREADY 0, WREADY 0, ARREADY 0.
- While S_AXI_ARESET is asserted, all READY outputs stay 0. READYs go high on the first edge after deassertion.
- Reset asserted mid-transaction: all buffers and pending responses are discarded immediately. No response is issued after reset.
- Write with AW and W accepted together at edge 0: commit and BVALID=1 at edge 1, and the register value is visible on ctrl_regs after edge 1. Earliest next AW/W accept: the edge after B completes.
- Read accepted at edge 0: RVALID=1 after edge 0, i.e. 1 cycle latency.
- With READY held high, sustained throughput is 1 read per 2 cycles and 1 write per 3 cycles. The read and write paths run concurrently.
- cmd_pulse is high for exactly the commit cycle and is 0 on every other cycle. It is registered.

## Test plan
- Reset, then sequential writes 0x1, 0x2, 0x3, 0x4 to 0x00..0x0C, then reads back 0x00..0x0C -> RDATA 0x1..0x4, all BRESP/RRESP OKAY, and ctrl_regs = {4,3,2,1}.
- Write 0xAABBCCDD to 0x04 with WSTRB=4'b0101 over a previous value of 0x00000002 -> readback 0x00BB00DD.
- W presented 3 cycles before AW, with BREADY held low 5 cycles -> BVALID stays high and AW/W READY stay low until the B handshake, and exactly one write occurs.
- Write 0x00000081 to 0x14 -> cmd_pulse = 0x81 for one cycle, then 0. Read 0x14 -> 0. Drive status_in=0xDEADBEEF and read 0x10 -> 0xDEADBEEF.
- Write and read at 0x3C -> BRESP = 2'b10, RRESP = 2'b10, RDATA 0, and no control register changes.
- Assert S_AXI_ARESET while BVALID=1 and a read is pending -> BVALID, RVALID and ctrl_regs go to 0 immediately; the first post-reset read of 0x00 returns 0.
